// File: rtl/da_lut_builder_pkg.sv
// Shared types and helpers for the DA LUT builder: FSM state encoding,
// default geometry, Gray-code and trailing-zero-count functions.
package da_pkg;

    localparam int DA_TAPS = 4;
    localparam int DA_CW   = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_BUILD   = 2'd2,
        ST_DONE    = 2'd3
    } da_state_e;

    function automatic logic [31:0] gray_code(input logic [31:0] i);
        return i ^ (i >> 1);
    endfunction

    // Index of the lowest set bit; 0 for a zero argument.
    function automatic int unsigned tz_count(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int k = 31; k >= 0; k--) begin
            if (v[k]) n = k;
        end
        return n;
    endfunction

endpackage

// File: rtl/da_lut_builder_gray_step.sv
// Step counter for the LUT build walk: presents the Gray address and the
// toggled bit index of the step that follows the one currently being written.
module da_gray_step
    import da_pkg::*;
#(
    parameter int TAPS = DA_TAPS,
    parameter int BW   = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear_i,
    input  logic            advance_i,
    output logic [TAPS-1:0] nxt_addr_o,
    output logic [BW-1:0]   nxt_bit_o,
    output logic            last_o
);

    logic [TAPS-1:0] step_q;
    logic [TAPS-1:0] step_d;
    logic [TAPS-1:0] step_nxt;

    always_comb begin
        step_d = step_q;
        if (clear_i) begin
            step_d = '0;
        end else if (advance_i) begin
            step_d = step_q + TAPS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_q <= '0;
        end else begin
            step_q <= step_d;
        end
    end

    assign step_nxt   = step_q + TAPS'(1);
    assign nxt_addr_o = TAPS'(gray_code(32'(step_nxt)));
    assign nxt_bit_o  = BW'(tz_count(32'(step_nxt)));
    assign last_o     = &step_q;

endmodule

// File: rtl/da_lut_builder.sv
// Collects TAPS signed coefficients and writes all 2^TAPS DA partial sums to the
// ROM in Gray order. Optional running checksum output under DA_LUT_CHECKSUM_EN.
//
// state   | meaning
// IDLE    | waiting for load_start, ROM port idle
// COLLECT | coef_ready high, taking h[0..TAPS-1]
// BUILD   | one ROM write per cycle, 2^TAPS cycles
// DONE    | LUT valid, done held until load_start or reset
module da_lut_builder
    import da_pkg::*;
#(
    parameter int TAPS = DA_TAPS,
    parameter int CW   = DA_CW,
    parameter int LW   = CW + TAPS
) (
`ifdef DA_LUT_CHECKSUM_EN
    output logic signed [LW+TAPS-1:0] lut_sum,
`endif
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_start,
    input  logic signed [CW-1:0] coef_in,
    input  logic                 coef_valid,
    output logic                 coef_ready,
    output logic                 rom_cen,
    output logic                 rom_wen,
    output logic [TAPS-1:0]      rom_addr,
    output logic signed [LW-1:0] rom_d,
    output logic                 busy,
    output logic                 done
);

    localparam int BW = (TAPS > 1) ? $clog2(TAPS) : 1;

    da_state_e state_q, state_d;

    logic [BW-1:0]        tap_q, tap_d;
    logic signed [CW-1:0] h_q [TAPS];
    logic signed [CW-1:0] h_d [TAPS];

    logic [TAPS-1:0]      rom_addr_q, rom_addr_d;
    logic signed [LW-1:0] rom_d_q, rom_d_d;
    logic                 coef_ready_q, coef_ready_d;
    logic                 rom_cen_q, rom_cen_d;
    logic                 rom_wen_q, rom_wen_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 accept;
    logic                 last_accept;
    logic [TAPS-1:0]      nxt_addr;
    logic [BW-1:0]        nxt_bit;
    logic                 step_last;
    logic signed [LW-1:0] h_ext;

    assign accept      = coef_valid & coef_ready_q;
    assign last_accept = accept && (tap_q == BW'(TAPS - 1));

    da_gray_step #(
        .TAPS (TAPS),
        .BW   (BW)
    ) u_step (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (last_accept),
        .advance_i  (state_q == ST_BUILD),
        .nxt_addr_o (nxt_addr),
        .nxt_bit_o  (nxt_bit),
        .last_o     (step_last)
    );

    assign h_ext = LW'(h_q[nxt_bit]);

    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        h_d        = h_q;
        rom_addr_d = rom_addr_q;
        rom_d_d    = rom_d_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_start) begin
                    state_d = ST_COLLECT;
                    tap_d   = '0;
                end
            end
            ST_COLLECT: begin
                if (accept) begin
                    h_d[tap_q] = coef_in;
                    tap_d      = tap_q + BW'(1);
                    if (last_accept) begin
                        state_d    = ST_BUILD;
                        rom_addr_d = '0;
                        rom_d_d    = '0;
                    end
                end
            end
            ST_BUILD: begin
                if (step_last) begin
                    state_d = ST_DONE;
                end else begin
                    // rom_d_q doubles as the running accumulator between steps
                    rom_addr_d = nxt_addr;
                    rom_d_d    = nxt_addr[nxt_bit] ? (rom_d_q + h_ext) : (rom_d_q - h_ext);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        coef_ready_d = (state_d == ST_COLLECT);
        busy_d       = (state_d == ST_COLLECT) || (state_d == ST_BUILD);
        done_d       = (state_d == ST_DONE);
        rom_cen_d    = (state_d != ST_BUILD);
        rom_wen_d    = (state_d != ST_BUILD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tap_q        <= '0;
            for (int k = 0; k < TAPS; k++) h_q[k] <= '0;
            rom_addr_q   <= '0;
            rom_d_q      <= '0;
            coef_ready_q <= 1'b0;
            rom_cen_q    <= 1'b1;
            rom_wen_q    <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            h_q          <= h_d;
            rom_addr_q   <= rom_addr_d;
            rom_d_q      <= rom_d_d;
            coef_ready_q <= coef_ready_d;
            rom_cen_q    <= rom_cen_d;
            rom_wen_q    <= rom_wen_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign coef_ready = coef_ready_q;
    assign rom_cen    = rom_cen_q;
    assign rom_wen    = rom_wen_q;
    assign rom_addr   = rom_addr_q;
    assign rom_d      = rom_d_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef DA_LUT_CHECKSUM_EN
    logic signed [LW+TAPS-1:0] lut_sum_q, lut_sum_d;

    always_comb begin
        lut_sum_d = lut_sum_q;
        if (load_start && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
            lut_sum_d = '0;
        end else if (!rom_wen_q) begin
            lut_sum_d = lut_sum_q + (LW+TAPS)'(rom_d_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lut_sum_q <= '0;
        end else begin
            lut_sum_q <= lut_sum_d;
        end
    end

    assign lut_sum = lut_sum_q;
`endif

endmodule

// File: tb/tb_da_lut_builder.sv
// Randomized self-checking bench for da_lut_builder against a subset-sum LUT model.
module tb_da_lut_builder;

    localparam int TAPS = 4;
    localparam int CW   = 16;
    localparam int LW   = CW + TAPS;
    localparam int N    = 1 << TAPS;
    localparam longint EMPTY = 64'd999999999;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 load_start;
    logic signed [CW-1:0] coef_in;
    logic                 coef_valid;
    logic                 coef_ready;
    logic                 rom_cen;
    logic                 rom_wen;
    logic [TAPS-1:0]      rom_addr;
    logic signed [LW-1:0] rom_d;
    logic                 busy;
    logic                 done;
`ifdef DA_LUT_CHECKSUM_EN
    logic signed [LW+TAPS-1:0] lut_sum;
`endif

    int     n_vec = 0;
    int     n_err = 0;
    longint rom_img [N];

    always #5 clk = ~clk;

    da_lut_builder dut (
`ifdef DA_LUT_CHECKSUM_EN
        .lut_sum    (lut_sum),
`endif
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .coef_in    (coef_in),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .rom_cen    (rom_cen),
        .rom_wen    (rom_wen),
        .rom_addr   (rom_addr),
        .rom_d      (rom_d),
        .busy       (busy),
        .done       (done)
    );

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Entry a is the sum of the taps selected by the set bits of a.
    function automatic longint lut_model(input int hv[4], input int a);
        longint s = 0;
        for (int k = 0; k < TAPS; k++) begin
            if (((a >> k) & 1) == 1) s += hv[k];
        end
        return s;
    endfunction

    task automatic check_reset_outs(input string tag);
        check_val({tag, "_ready"}, coef_ready, 0);
        check_val({tag, "_cen"},   rom_cen,    1);
        check_val({tag, "_wen"},   rom_wen,    1);
        check_val({tag, "_addr"},  rom_addr,   0);
        check_val({tag, "_d"},     rom_d,      0);
        check_val({tag, "_busy"},  busy,       0);
        check_val({tag, "_done"},  done,       0);
    endtask

    // mode: 0 valid every cycle, 1 valid every 3rd cycle, 2 random valid.
    // abort_step >= 0 asserts reset while that BUILD step is on the ROM port.
    // noisy pulses load_start randomly whenever the block reports busy.
    task automatic run_load(input int hv[4], input int mode, input int abort_step, input bit noisy);
        int acc_n = 0;
        int last_acc = -1000;
        int widx = 0;
        int done_k = -1;
        bit v;
        bit r;
        longint hsum = 0;

        for (int a = 0; a < N; a++) rom_img[a] = EMPTY;
        for (int k = 0; k < TAPS; k++) hsum += hv[k];

        @(negedge clk);
        load_start = 1'b1;
        coef_valid = 1'b0;
        @(negedge clk);
        load_start = 1'b0;
        check_val("ready_rise", coef_ready, 1);
        check_val("done_clear", done, 0);

        for (int k = 0; k < 400; k++) begin
            if (!rom_cen) begin
                check_val("wr_wen", rom_wen, 0);
                if (widx == 0) check_val("first_wr_lat", k - last_acc, 1);
                check_val("wr_order", rom_addr, widx ^ (widx >> 1));
                check_val("wr_data", rom_d, lut_model(hv, int'(rom_addr)));
                rom_img[rom_addr] = rom_d;
                if (widx == abort_step) begin
                    reset      = 1'b1;
                    coef_valid = 1'b0;
                    load_start = 1'b0;
                    @(negedge clk);
                    reset = 1'b0;
                    check_reset_outs("abort");
                    return;
                end
                widx++;
            end
            if (done) begin
                done_k = k;
                break;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = ((k % 3) == 2);
                default: v = 1'($urandom_range(0, 1));
            endcase
            coef_valid = v;
            coef_in    = (acc_n < TAPS) ? CW'(hv[acc_n]) : CW'($urandom);
            load_start = noisy && busy && ($urandom_range(0, 3) == 0);
            r = coef_ready;
            @(negedge clk);
            if (v && r) begin
                acc_n++;
                if (acc_n <= TAPS) last_acc = k;
            end
        end

        coef_valid = 1'b0;
        load_start = 1'b0;
        check_val("done_seen", (done_k >= 0) ? 1 : 0, 1);
        if (done_k >= 0) begin
            check_val("accepts",   acc_n, TAPS);
            check_val("writes",    widx, N);
            check_val("done_lat",  done_k - last_acc, N + 1);
            check_val("busy_fall", busy, 0);
            check_val("cen_idle",  rom_cen, 1);
            check_val("wen_idle",  rom_wen, 1);
            for (int a = 0; a < N; a++) check_val("lut_full", rom_img[a], lut_model(hv, a));
`ifdef DA_LUT_CHECKSUM_EN
            check_val("lut_sum", lut_sum, hsum * (N / 2));
`endif
        end
    endtask

    initial begin
        int h1[4];
        int h2[4];
        int h3[4];
        int hr[4];

        h1 = '{1, 2, 3, 4};
        h2 = '{-32768, -32768, -32768, -32768};
        h3 = '{5, 0, 0, -5};

        reset      = 1'b1;
        load_start = 1'b0;
        coef_valid = 1'b0;
        coef_in    = '0;
        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        reset = 1'b0;

        run_load(h1, 0, -1, 1'b0);
        check_val("h1_rom0",  rom_img[0],  0);
        check_val("h1_rom5",  rom_img[5],  4);
        check_val("h1_rom10", rom_img[10], 6);
        check_val("h1_rom15", rom_img[15], 10);

        run_load(h2, 0, -1, 1'b0);
        check_val("neg_rom15", rom_img[15], -131072);
        check_val("neg_rom3",  rom_img[3],  -65536);

        run_load(h1, 1, -1, 1'b0);
        check_val("stall_rom15", rom_img[15], 10);

        run_load(h3, 0, -1, 1'b0);
        check_val("rebuild_rom9", rom_img[9], 0);
        check_val("rebuild_rom1", rom_img[1], 5);

        run_load(h1, 0, 7, 1'b0);
        run_load(h1, 2, -1, 1'b1);

        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < TAPS; k++) hr[k] = int'($signed(16'($urandom)));
            run_load(hr, int'($urandom_range(0, 2)), -1, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
